// File: rtl/mips_pkg.sv
// Shared MIPS-32 encoding constants: opcodes, the JR function code, and instruction field positions.
package mips_pkg;

   localparam logic [5:0] R_TYPE   = 6'h00;
   localparam logic [5:0] ADDI     = 6'h08;
   localparam logic [5:0] ADDIU    = 6'h09;
   localparam logic [5:0] SLTI     = 6'h0A;
   localparam logic [5:0] SLTIU    = 6'h0B;
   localparam logic [5:0] ANDI     = 6'h0C;
   localparam logic [5:0] ORI      = 6'h0D;
   localparam logic [5:0] XORI     = 6'h0E;
   localparam logic [5:0] LUI      = 6'h0F;
   localparam logic [5:0] LB       = 6'h20;
   localparam logic [5:0] LH       = 6'h21;
   localparam logic [5:0] LW       = 6'h23;
   localparam logic [5:0] LBU      = 6'h24;
   localparam logic [5:0] LHU      = 6'h25;
   localparam logic [5:0] LWU      = 6'h27;
   localparam logic [5:0] SB       = 6'h28;
   localparam logic [5:0] SH       = 6'h29;
   localparam logic [5:0] SW       = 6'h2B;
   localparam logic [5:0] JR_FUNCT = 6'h08;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int IMM_MSB   = 15;
   localparam int FUNCT_MSB = 5;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src_imm;
   } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file: two bypassed read ports, one write port, a debug read port and asynchronous clear.
module id_regfile #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_write,
   input  logic [NB_REG-1:0]  i_write_addr,
   input  logic [NB_DATA-1:0] i_write_data,
   input  logic [NB_REG-1:0]  i_read_addr_1,
   input  logic [NB_REG-1:0]  i_read_addr_2,
   input  logic [NB_REG-1:0]  i_read_addr_debug,
   output logic [NB_DATA-1:0] o_read_data_1,
   output logic [NB_DATA-1:0] o_read_data_2,
   output logic [NB_DATA-1:0] o_read_data_debug
);

   localparam int DEPTH = 2**NB_REG;

   logic [NB_DATA-1:0] regs [DEPTH];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (i_enable && i_write && (i_write_addr != '0)) begin
         regs[i_write_addr] <= i_write_data;
      end
   end

   // Same-cycle write-back is forwarded so a decode never sees a stale operand.
   assign o_read_data_1 = (i_read_addr_1 == '0) ? '0 :
                          (i_write && (i_write_addr == i_read_addr_1)) ? i_write_data :
                          regs[i_read_addr_1];
   assign o_read_data_2 = (i_read_addr_2 == '0) ? '0 :
                          (i_write && (i_write_addr == i_read_addr_2)) ? i_write_data :
                          regs[i_read_addr_2];
   assign o_read_data_debug = (i_read_addr_debug == '0) ? '0 : regs[i_read_addr_debug];

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: decoder, immediate extender, load-use hazard detection and ID/EX register.
module id_stage_pipelined
   import mips_pkg::*;
#(
   parameter int NB_ADDR = 32,
   parameter int NB_INST = 32,
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_valid,
   input  logic [NB_INST-1:0] i_instruction,
   input  logic [NB_ADDR-1:0] i_pc,
   input  logic               i_flush,
   input  logic               i_wb_write,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_DATA-1:0] i_wb_data,
   input  logic [NB_REG-1:0]  i_address_read_debug,
   output logic               o_stall,
   output logic               o_valid,
   output logic [NB_ADDR-1:0] o_pc,
   output logic [5:0]         o_opcode,
   output logic [5:0]         o_funct,
   output logic [NB_DATA-1:0] o_data_1,
   output logic [NB_DATA-1:0] o_data_2,
   output logic [NB_DATA-1:0] o_sign_extend,
   output logic [NB_REG-1:0]  o_dest,
   output logic [NB_REG-1:0]  o_rs,
   output logic [NB_REG-1:0]  o_rt,
   output logic               o_reg_write,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic               o_mem_to_reg,
   output logic               o_alu_src_imm,
   output logic [NB_DATA-1:0] o_data_read_debug
);

   function automatic logic signed [NB_DATA-1:0] extend_imm(input logic [15:0] imm,
                                                             input logic      zero_ext);
      logic signed [15:0]        simm;
      logic signed [NB_DATA-1:0] res;
      simm = signed'(imm);
      if (zero_ext) res = NB_DATA'(imm);
      else          res = NB_DATA'(simm);
      return res;
   endfunction

   logic [5:0]         opcode, funct;
   logic [NB_REG-1:0]  rs, rt, rd, dest;
   logic [15:0]        imm;
   logic               zero_ext, reads_rt, bubble;
   ctrl_t              ctrl;
   logic [NB_DATA-1:0] rdata_1, rdata_2, ext_imm;

   assign opcode = i_instruction[OP_MSB:OP_LSB];
   assign funct  = i_instruction[FUNCT_MSB:0];
   assign rs     = NB_REG'(i_instruction[RS_MSB:RS_LSB]);
   assign rt     = NB_REG'(i_instruction[RT_MSB:RT_LSB]);
   assign rd     = NB_REG'(i_instruction[RD_MSB:RD_LSB]);
   assign imm    = i_instruction[IMM_MSB:0];

   always_comb begin
      ctrl     = '0;
      dest     = '0;
      zero_ext = 1'b0;
      reads_rt = 1'b0;
      case (opcode)
         R_TYPE: begin
            dest           = rd;
            ctrl.reg_write = (funct != JR_FUNCT);
            reads_rt       = 1'b1;
         end
         ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: begin
            dest             = rt;
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            zero_ext         = (opcode == ANDI) || (opcode == ORI) || (opcode == XORI);
         end
         LB, LH, LW, LBU, LHU, LWU: begin
            dest             = rt;
            ctrl.reg_write   = 1'b1;
            ctrl.mem_read    = 1'b1;
            ctrl.mem_to_reg  = 1'b1;
            ctrl.alu_src_imm = 1'b1;
         end
         SB, SH, SW: begin
            ctrl.mem_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            reads_rt         = 1'b1;
         end
         default: ;
      endcase
      if (dest == '0) ctrl.reg_write = 1'b0;
   end

   assign ext_imm = extend_imm(imm, zero_ext);

   id_regfile #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_regfile (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_enable          (i_enable),
      .i_write           (i_wb_write),
      .i_write_addr      (i_wb_addr),
      .i_write_data      (i_wb_data),
      .i_read_addr_1     (rs),
      .i_read_addr_2     (rt),
      .i_read_addr_debug (i_address_read_debug),
      .o_read_data_1     (rdata_1),
      .o_read_data_2     (rdata_2),
      .o_read_data_debug (o_data_read_debug)
   );

   // A load in EX whose destination feeds this instruction must wait one cycle for its data.
   assign o_stall = i_valid && o_valid && o_mem_read && (o_dest != '0) &&
                    ((o_dest == rs) || (reads_rt && (o_dest == rt)));
   assign bubble  = i_flush || o_stall || !i_valid;

   // ID/EX pipeline register boundary
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset || (i_enable && bubble)) begin
         o_valid       <= 1'b0;
         o_pc          <= '0;
         o_opcode      <= '0;
         o_funct       <= '0;
         o_data_1      <= '0;
         o_data_2      <= '0;
         o_sign_extend <= '0;
         o_dest        <= '0;
         o_rs          <= '0;
         o_rt          <= '0;
         o_reg_write   <= 1'b0;
         o_mem_read    <= 1'b0;
         o_mem_write   <= 1'b0;
         o_mem_to_reg  <= 1'b0;
         o_alu_src_imm <= 1'b0;
      end else if (i_enable) begin
         o_valid       <= 1'b1;
         o_pc          <= i_pc;
         o_opcode      <= opcode;
         o_funct       <= funct;
         o_data_1      <= rdata_1;
         o_data_2      <= rdata_2;
         o_sign_extend <= ext_imm;
         o_dest        <= dest;
         o_rs          <= rs;
         o_rt          <= rt;
         o_reg_write   <= ctrl.reg_write;
         o_mem_read    <= ctrl.mem_read;
         o_mem_write   <= ctrl.mem_write;
         o_mem_to_reg  <= ctrl.mem_to_reg;
         o_alu_src_imm <= ctrl.alu_src_imm;
      end
   end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: a behavioural decode/hazard model predicts each ID/EX load.
module tb_id_stage_pipelined;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_enable, i_valid, i_flush, i_wb_write;
   logic [31:0] i_instruction, i_pc, i_wb_data;
   logic [4:0]  i_wb_addr, i_address_read_debug;
   logic        o_stall, o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src_imm;
   logic [31:0] o_pc, o_data_1, o_data_2, o_sign_extend, o_data_read_debug;
   logic [5:0]  o_opcode, o_funct;
   logic [4:0]  o_dest, o_rs, o_rt;

   always #5 i_clk = ~i_clk;

   id_stage_pipelined dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
      .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
      .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .i_address_read_debug(i_address_read_debug),
      .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc), .o_opcode(o_opcode), .o_funct(o_funct),
      .o_data_1(o_data_1), .o_data_2(o_data_2), .o_sign_extend(o_sign_extend), .o_dest(o_dest),
      .o_rs(o_rs), .o_rt(o_rt), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
      .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_alu_src_imm(o_alu_src_imm),
      .o_data_read_debug(o_data_read_debug)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  opcode, funct;
      logic [31:0] d1, d2, sext;
      logic [4:0]  dest, rs, rt;
      logic        rw, mr, mw, m2r, asi;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        m_q;
   logic [31:0] m_regs [32];
   logic        last_stall;
   int          checks = 0;
   int          errors = 0;

   function automatic rec_t actual();
      rec_t a;
      a = '{o_valid, o_pc, o_opcode, o_funct, o_data_1, o_data_2, o_sign_extend,
            o_dest, o_rs, o_rt, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src_imm};
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (i_wb_write && (i_wb_addr == a)) return i_wb_data;
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_q = '0;
      last_stall = 1'b0;
   endtask

   // Reference model: decode table from the MIPS opcode map, hazard rule, then ID/EX priority.
   task automatic model_step();
      rec_t        c;
      logic        reads_rt, stall_exp;
      logic [5:0]  op;
      logic [15:0] imm;
      c   = '0;
      op  = i_instruction[31:26];
      imm = i_instruction[15:0];
      reads_rt = 1'b0;
      c.valid  = 1'b1;
      c.pc     = i_pc;
      c.opcode = op;
      c.funct  = i_instruction[5:0];
      c.rs     = i_instruction[25:21];
      c.rt     = i_instruction[20:16];
      c.d1     = m_read(c.rs);
      c.d2     = m_read(c.rt);
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) c.sext = {16'h0000, imm};
      else c.sext = {{16{imm[15]}}, imm};
      if (op == 6'h00) begin
         c.dest = i_instruction[15:11]; c.rw = (c.funct != 6'h08); reads_rt = 1'b1;
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         c.dest = c.rt; c.rw = 1'b1; c.asi = 1'b1;
      end else if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25 || op == 6'h27) begin
         c.dest = c.rt; c.rw = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; c.asi = 1'b1;
      end else if (op == 6'h28 || op == 6'h29 || op == 6'h2B) begin
         c.mw = 1'b1; c.asi = 1'b1; reads_rt = 1'b1;
      end
      if (c.dest == 5'd0) c.rw = 1'b0;
      stall_exp = i_valid && m_q.valid && m_q.mr && (m_q.dest != 5'd0) &&
                  ((m_q.dest == c.rs) || (reads_rt && (m_q.dest == c.rt)));
      check("stall", {31'd0, o_stall}, {31'd0, stall_exp});
      check("debug_read", o_data_read_debug,
            (i_address_read_debug == 5'd0) ? 32'd0 : m_regs[i_address_read_debug]);
      if (i_enable) begin
         m_q = (i_flush || stall_exp || !i_valid) ? rec_t'(0) : c;
         if (i_wb_write && i_wb_addr != 5'd0) m_regs[i_wb_addr] = i_wb_data;
      end
      exp_q.push_back(m_q);
      last_stall = stall_exp;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic en,
                        input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic [4:0] dbg);
      @(negedge i_clk);
      i_valid = v; i_instruction = ins; i_pc = $urandom() & 32'hFFFF_FFFC; i_flush = fl;
      i_enable = en; i_wb_write = wbw; i_wb_addr = wba; i_wb_data = wbd; i_address_read_debug = dbg;
      #1 model_step();
   endtask

   task automatic after_edge();
      @(posedge i_clk);
      #2;
   endtask

   initial begin : monitor
      rec_t e, a;
      forever begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL idex: got %h expected %h at %0t", a, e, $time);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] ADDI_M5  = 32'h2002FFFB;
   localparam logic [31:0] ADD_433  = 32'h00632020;
   localparam logic [31:0] LW_5_1   = 32'h8C250000;
   localparam logic [31:0] ADD_650  = 32'h00A03020;
   localparam logic [31:0] ORI_7    = 32'h34078000;
   localparam logic [31:0] SW_2_1   = 32'hAC220004;

   initial begin : stimulus
      logic [31:0] ins;
      logic [5:0]  op;
      i_enable = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_wb_write = 1'b0;
      i_instruction = '0; i_pc = '0; i_wb_addr = '0; i_wb_data = '0; i_address_read_debug = '0;
      m_reset();
      #1 i_reset = 1'b1;
      #2;
      check("reset_idex_any_bit", {31'd0, |actual()}, 32'd0);
      check("reset_stall", {31'd0, o_stall}, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;

      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h10, 5'd1);
      drive(1'b1, ADDI_M5, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd1);
      after_edge();
      check("addi_sext", o_sign_extend, 32'hFFFF_FFFB);
      check("addi_dest", {27'd0, o_dest}, 32'd2);
      check("addi_ctrl", {30'd0, o_reg_write, o_alu_src_imm}, 32'd3);

      drive(1'b1, ADD_433, 1'b0, 1'b1, 1'b1, 5'd3, 32'h1234, 5'd3);
      after_edge();
      check("bypass_d1", o_data_1, 32'h1234);
      check("bypass_d2", o_data_2, 32'h1234);

      drive(1'b1, LW_5_1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0);
      drive(1'b1, ADD_650, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0);
      check("loaduse_stall", {31'd0, o_stall}, 32'd1);
      after_edge();
      check("loaduse_bubble", {31'd0, o_valid}, 32'd0);
      drive(1'b1, ADD_650, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0);
      check("loaduse_released", {31'd0, o_stall}, 32'd0);
      after_edge();
      check("add_issued_rs", {27'd0, o_rs}, 32'd5);

      drive(1'b1, ORI_7, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF, 5'd0);
      after_edge();
      check("ori_zext", o_sign_extend, 32'h0000_8000);
      check("reg0_debug", o_data_read_debug, 32'd0);

      drive(1'b1, SW_2_1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 5'd2);
      after_edge();
      check("flush_valid", {31'd0, o_valid}, 32'd0);
      check("flush_memw", {31'd0, o_mem_write}, 32'd0);

      drive(1'b1, ADDI_M5, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd2);
      drive(1'b1, ORI_7, 1'b0, 1'b0, 1'b1, 5'd9, 32'hDEAD, 5'd9);
      after_edge();
      check("hold_dest", {27'd0, o_dest}, 32'd2);
      check("hold_sext", o_sign_extend, 32'hFFFF_FFFB);

      drive(1'b1, LW_5_1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0);
      @(negedge i_clk);
      i_valid = 1'b1; i_instruction = ADD_650; i_flush = 1'b0; i_enable = 1'b1; i_wb_write = 1'b0;
      #1;
      check("pre_reset_stall", {31'd0, o_stall}, 32'd1);
      i_reset = 1'b1;
      #1;
      check("midstall_reset_stall", {31'd0, o_stall}, 32'd0);
      check("midstall_reset_idex", {31'd0, |actual()}, 32'd0);
      m_reset();
      #1 i_reset = 1'b0;
      #1 model_step();
      after_edge();
      check("post_reset_load", {31'd0, o_valid}, 32'd1);

      ins = ADD_650;
      for (int n = 0; n < 2000; n++) begin
         if (!(last_stall && i_enable)) begin
            case ($urandom_range(0, 5))
               0:       op = 6'h00;
               1:       op = 6'h08 + 6'($urandom_range(0, 7));
               2, 5:    op = (6'($urandom_range(0, 5)) == 6'd0) ? 6'h20 : 6'h23;
               3:       op = 6'h28 | 6'($urandom_range(0, 1)) | (6'($urandom_range(0, 1)) << 1);
               default: op = 6'($urandom());
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
            if (op == 6'h00 && $urandom_range(0, 1) == 0) ins[5:0] = 6'h20;
         end
         drive($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)));
      end

      @(negedge i_clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised successor to the instruction-decode stage of the MIPS pipeline. It decodes the incoming instruction and reads a 2**NB_REG-entry register file with write-back bypass. It detects load-use hazards and stalls IF, and registers all decoded fields into an ID/EX pipeline register with valid, flush and bubble insertion. It sits between the IF/ID latch and the EX stage, and receives write-back from WB and flush from branch resolution in EX.

## Interface
- NB_ADDR, 32, PC width
- NB_INST, 32, instruction width (fixed MIPS-32 field layout)
- NB_DATA, 32, register/data width; must be ≥ 16
- NB_REG, 5, register address width; register file depth = 2**NB_REG
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  debug step enable; 0 freezes all state (ID/EX register and register-file writes)
- i_valid  in  1  IF/ID holds a real instruction
- i_instruction  in  NB_INST  instruction from IF/ID
- i_pc  in  NB_ADDR  PC+4 from IF/ID
- i_flush  in  1  kill the instruction entering ID/EX (taken branch/jump in EX)
- i_wb_write, i_wb_addr, i_wb_data  in  1 / NB_REG / NB_DATA  write-back port
- i_address_read_debug  in  NB_REG  debug read address
- o_stall  out  1  hold PC and IF/ID this cycle
- o_valid  out  1  ID/EX holds a real instruction
- o_pc  out  NB_ADDR  registered PC
- o_opcode, o_funct  out  6 / 6  registered fields
- o_data_1, o_data_2  out  NB_DATA  registered rs/rt operands
- o_sign_extend  out  NB_DATA  registered extended immediate
- o_dest  out  NB_REG  registered destination register
- o_rs, o_rt  out  NB_REG  registered source addresses (for EX forwarding)
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src_imm  out  1 each  registered controls
- o_data_read_debug  out  NB_DATA  combinational debug read

## Operation
- Decode (combinational): rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26], funct=[5:0].
- Opcode 0x00 (R-type): dest=rd, reg_write=1 except funct 0x08 (JR).
- 0x08–0x0F (ADDI..LUI): dest=rt, reg_write=1, alu_src_imm=1.
- 0x20,0x21,0x23,0x24,0x25,0x27 (loads): dest=rt, reg_write, mem_read, mem_to_reg, alu_src_imm.
- 0x28,0x29,0x2B (stores): mem_write, alu_src_imm, dest=0.
- Any other opcode: all controls 0.
- reg_write is forced 0 when dest==0.
- Immediate: zero-extend for 0x0C/0x0D/0x0E (ANDI/ORI/XORI); otherwise sign-extend to NB_DATA.
- Register file reads: register 0 always reads 0, and writes to register 0 are ignored. When i_wb_write=1, i_wb_addr equals the read address and the address is nonzero, the read returns i_wb_data in the same cycle.
- Load-use hazard: o_stall=1 when all of the following hold:
  - i_valid=1 and o_valid=1 and o_mem_read=1 and o_dest≠0;
  - o_dest matches rs, or matches rt for an instruction that reads rt (R-type, stores).
- ID/EX update priority, evaluated each edge with i_enable=1: i_flush, then stall, then !i_valid, each inserting a bubble. Otherwise the decoded instruction is loaded.
- A bubble sets o_valid=0 and all controls 0. Data fields in a bubble are don't-care but held at 0.

## Timing
- Reset (asynchronous): every registered output is 0, every register-file entry is 0, and o_stall=0.
- Latency: the instruction presented in cycle N appears on the ID/EX outputs after edge N+1.
- Register-file write takes effect at the edge. The bypass gives write-then-read semantics within one cycle.
- o_stall is combinational from the ID/EX contents and the current instruction. A load-use stall lasts exactly one cycle, because the bubble clears o_mem_read.
- Flush and stall in the same cycle: a bubble is inserted and o_stall stays asserted. IF holds, so the stalled instruction is re-decoded next cycle.
- i_enable=0: ID/EX and register file hold their state, and o_stall still reflects the current state. o_data_read_debug is always live.
- Reset mid-stall: outputs clear immediately, and the next edge loads normally.

## Structure
- Shared package mips_pkg: opcode/funct localparams (R_TYPE, ADDI…LUI, LB…LWU, SB/SH/SW, JR_FUNCT) and field bit positions.
- Sub-module id_regfile: parametrised NB_DATA/NB_REG, two read ports with bypass, one write port, debug read port, asynchronous reset clear.
- Top level contains the decoder, extender, hazard logic and ID/EX register.

## Test plan
- Reset, then ADDI $2,$0,-5 (0x2002FFFB): o_sign_extend=0xFFFFFFFB, o_dest=2, o_reg_write=1 and o_alu_src_imm=1 after one edge.
- WB writes $3=0x1234 while ADD $4,$3,$3 is decoded in the same cycle: o_data_1=o_data_2=0x1234 after the edge.
- LW $5,0($1), then ADD $6,$5,$0: o_stall=1 for exactly one cycle, a bubble with o_valid=0 is inserted, then ADD issues with o_rs=5.
- ORI $7,$0,0x8000: o_sign_extend=0x00008000. Writing 0xFFFF to $0 via WB: debug read of $0 returns 0.
- i_flush=1 while a valid SW is decoded: o_valid=0 and o_mem_write=0. With i_enable=0, the outputs hold their previous values.
- Assert i_reset while a stall is pending: all outputs are 0 immediately and o_stall=0.
